// File: rtl/noc_router_xy.sv
// ============================================================================
// noc_router_xy
// ----------------------------------------------------------------------------
// Five-port wormhole-free mesh router with XY dimension-order routing.
// Every input has its own small FIFO; each FIFO head is routed on its signed
// x/y hop fields, arbitrated round-robin per output, and forwarded into a
// one-entry output register with its hop field moved one step closer to zero.
//
// Port order for all 5-wide buses: 0=PE, 1=N, 2=S, 3=E, 4=W.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_data    : 5*DATA_W, one flit per input port
//   in_valid   : 5, per-input flit valid
//   in_ready   : 5, per-input accept (input FIFO not full)
//   out_data   : 5*DATA_W, one flit per output port
//   out_valid  : 5, per-output flit valid
//   out_ready  : 5, per-output downstream accept
// ============================================================================
module noc_router_xy #(
    parameter int DATA_W     = 53,
    parameter int HOP_W      = 3,
    parameter int X_HOP_LOC  = 4,
    parameter int Y_HOP_LOC  = 7,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5*DATA_W-1:0]   in_data,
    input  logic [4:0]            in_valid,
    output logic [4:0]            in_ready,
    output logic [5*DATA_W-1:0]   out_data,
    output logic [4:0]            out_valid,
    input  logic [4:0]            out_ready
);

    localparam int NPORT = 5;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] PORT_PE = 3'd0;
    localparam logic [2:0] PORT_N  = 3'd1;
    localparam logic [2:0] PORT_S  = 3'd2;
    localparam logic [2:0] PORT_E  = 3'd3;
    localparam logic [2:0] PORT_W  = 3'd4;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem      [NPORT][FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr   [NPORT];
    logic [PTR_W-1:0]  r_rd_ptr   [NPORT];
    logic [CNT_W-1:0]  r_count    [NPORT];
    logic              r_ready_en;
    logic [DATA_W-1:0] r_out_data [NPORT];
    logic [NPORT-1:0]  r_out_valid;
    logic [2:0]        r_rr_ptr   [NPORT];

    // ------------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------------
    logic [NPORT-1:0]  w_head_vld;
    logic [NPORT-1:0]  w_push;
    logic [NPORT-1:0]  w_pop;
    logic [NPORT-1:0]  w_can_load;
    logic [NPORT-1:0]  w_gnt_vld;
    logic [2:0]        w_gnt_idx  [NPORT];
    logic [DATA_W-1:0] w_head     [NPORT];
    logic [DATA_W-1:0] w_fwd      [NPORT];
    logic [HOP_W-1:0]  w_x        [NPORT];
    logic [HOP_W-1:0]  w_y        [NPORT];
    logic [2:0]        w_dest     [NPORT];
    logic [3:0]        w_cand;

    // ------------------------------------------------------------------------
    // Handshake terms. in_ready depends only on registered occupancy plus an
    // enable that comes up on the first clock after reset release, so it is
    // held low throughout reset and never combinationally depends on in_valid.
    // ------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            w_head_vld[i] = (r_count[i] != '0);
            in_ready[i]   = r_ready_en && (r_count[i] != FULL_CNT);
            w_push[i]     = in_valid[i] && in_ready[i];
            w_can_load[i] = !r_out_valid[i] || out_ready[i];
        end
    end

    // ------------------------------------------------------------------------
    // XY route and hop rewrite of each FIFO head. X is resolved first; the
    // hop that is consumed moves one step toward zero. Hops only ever move
    // toward zero, so the full signed range is safe from wrap.
    // ------------------------------------------------------------------------
    // NOTE: every output of an always_comb gets a default before any branch,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            w_head[i] = r_mem[i][r_rd_ptr[i]];
            w_x[i]    = w_head[i][X_HOP_LOC +: HOP_W];
            w_y[i]    = w_head[i][Y_HOP_LOC +: HOP_W];
            w_fwd[i]  = w_head[i];
            w_dest[i] = PORT_PE;
            if (w_x[i] != '0) begin
                if (w_x[i][HOP_W-1]) begin
                    w_dest[i] = PORT_W;
                    w_fwd[i][X_HOP_LOC +: HOP_W] = w_x[i] + HOP_W'(1);
                end else begin
                    w_dest[i] = PORT_E;
                    w_fwd[i][X_HOP_LOC +: HOP_W] = w_x[i] - HOP_W'(1);
                end
            end else if (w_y[i] != '0) begin
                if (w_y[i][HOP_W-1]) begin
                    w_dest[i] = PORT_S;
                    w_fwd[i][Y_HOP_LOC +: HOP_W] = w_y[i] + HOP_W'(1);
                end else begin
                    w_dest[i] = PORT_N;
                    w_fwd[i][Y_HOP_LOC +: HOP_W] = w_y[i] - HOP_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-output round-robin arbiter. The search starts at r_rr_ptr and the
    // first requesting head wins. Each head requests exactly one output, so
    // an input can never collect two grants in one cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_pop     = '0;
        w_gnt_vld = '0;
        w_cand    = '0;
        for (int o = 0; o < NPORT; o++) begin
            w_gnt_idx[o] = '0;
            for (int k = 0; k < NPORT; k++) begin
                w_cand = {1'b0, r_rr_ptr[o]} + 4'(k);
                if (w_cand >= 4'd5) begin
                    w_cand = w_cand - 4'd5;
                end
                if (!w_gnt_vld[o] && w_can_load[o] &&
                    w_head_vld[w_cand[2:0]] && (w_dest[w_cand[2:0]] == 3'(o))) begin
                    w_gnt_vld[o] = 1'b1;
                    w_gnt_idx[o] = w_cand[2:0];
                end
            end
            if (w_gnt_vld[o]) begin
                w_pop[w_gnt_idx[o]] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Input FIFO control: pointers and occupancy.
    // ------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every always_ff sees the pre-edge values of all other registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready_en <= 1'b0;
            for (int i = 0; i < NPORT; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
        end else begin
            r_ready_en <= 1'b1;
            for (int i = 0; i < NPORT; i++) begin
                if (w_push[i]) begin
                    r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
                end
                if (w_pop[i]) begin
                    r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
                end
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_count[i] <= r_count[i] + CNT_W'(1);
                    2'b01:   r_count[i] <= r_count[i] - CNT_W'(1);
                    default: r_count[i] <= r_count[i];
                endcase
            end
        end
    end

    // NOTE: the FIFO storage has no reset; occupancy is reset instead, which
    // makes stale contents unreachable and keeps the array a plain RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NPORT; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wr_ptr[i]] <= in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output registers and arbiter pointers. A register reloads in the same
    // cycle it drains, giving one flit per cycle per output.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= '0;
            for (int o = 0; o < NPORT; o++) begin
                r_out_data[o] <= '0;
                r_rr_ptr[o]   <= '0;
            end
        end else begin
            for (int o = 0; o < NPORT; o++) begin
                if (w_gnt_vld[o]) begin
                    r_out_data[o]  <= w_fwd[w_gnt_idx[o]];
                    r_out_valid[o] <= 1'b1;
                    r_rr_ptr[o]    <= (w_gnt_idx[o] == 3'd4) ? 3'd0 : w_gnt_idx[o] + 3'd1;
                end else if (out_ready[o]) begin
                    r_out_valid[o] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int o = 0; o < NPORT; o++) begin
            out_data[o*DATA_W +: DATA_W] = r_out_data[o];
        end
    end

    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_noc_router_xy.sv
// ============================================================================
// tb_noc_router_xy
// ----------------------------------------------------------------------------
// Directed self-checking bench for noc_router_xy with default parameters
// (DATA_W=53, HOP_W=3, x hop at [6:4], y hop at [9:7], FIFO_DEPTH=2).
// Inputs are driven 1 ns after each rising edge and outputs are sampled at
// the same point, so every sample reflects the state left by the last edge.
// ============================================================================
module tb_noc_router_xy;

    localparam int DW = 53;
    localparam logic [DW-1:0] BASE = 53'h1F_0F0F_1234_5A5A;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [5*DW-1:0]   in_data = '0;
    logic [4:0]        in_valid = '0;
    logic [4:0]        in_ready;
    logic [5*DW-1:0]   out_data;
    logic [4:0]        out_valid;
    logic [4:0]        out_ready = 5'b11111;

    int checks   = 0;
    int failures = 0;

    noc_router_xy #(
        .DATA_W     (DW),
        .HOP_W      (3),
        .X_HOP_LOC  (4),
        .Y_HOP_LOC  (7),
        .FIFO_DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Payload tagged with a source id and sequence number, hop fields clear.
    function automatic logic [DW-1:0] pl(input int src, input int seq);
        logic [DW-1:0] f;
        f          = BASE;
        f[23:20]   = 4'(src);
        f[19:16]   = 4'(seq);
        f[9:4]     = '0;
        return f;
    endfunction

    function automatic logic [DW-1:0] mk(input logic [DW-1:0] p, input logic [2:0] x,
                                         input logic [2:0] y);
        logic [DW-1:0] f;
        f      = p;
        f[6:4] = x;
        f[9:7] = y;
        return f;
    endfunction

    function automatic logic [DW-1:0] od(input int p);
        return out_data[p*DW +: DW];
    endfunction

    task automatic drive(input int p, input logic [DW-1:0] f, input logic v);
        in_data[p*DW +: DW] = f;
        in_valid[p]         = v;
    endtask

    initial begin
        int            acc;
        int            rcv;
        int            hold_err;
        int            seen;
        int            first_cyc;
        int            last_cyc;
        int            sent [5];
        int            order [4];
        logic [DW-1:0] exp_f;

        // ---------------- reset ----------------
        #1 rst_n = 1'b0;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready",  64'(in_ready),  64'(0));
        check("rst_out_data",  64'(|out_data), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        check("in_ready_before_edge", 64'(in_ready), 64'(0));
        tick();
        check("in_ready_after_edge", 64'(in_ready), 64'h1f);

        // ---------------- PE x=+2 -> E with x=+1 ----------------
        drive(0, mk(pl(1, 0), 3'd2, 3'd0), 1'b1);
        tick();
        drive(0, '0, 1'b0);
        check("lat_not_yet", 64'(out_valid), 64'(0));
        tick();
        check("pe_to_e_valid", 64'(out_valid), 64'b01000);
        check("pe_to_e_data",  64'(od(3)), 64'(mk(pl(1, 0), 3'd1, 3'd0)));
        tick();
        check("pe_to_e_drained", 64'(out_valid), 64'(0));

        // ---------------- W y=-1 -> S y=0, then N -> PE ----------------
        drive(4, mk(pl(2, 0), 3'd0, 3'b111), 1'b1);
        tick();
        drive(4, '0, 1'b0);
        tick();
        check("w_to_s_valid", 64'(out_valid), 64'b00100);
        check("w_to_s_data",  64'(od(2)), 64'(mk(pl(2, 0), 3'd0, 3'd0)));
        drive(1, mk(pl(2, 0), 3'd0, 3'd0), 1'b1);
        tick();
        drive(1, '0, 1'b0);
        tick();
        check("n_to_pe_valid", 64'(out_valid), 64'b00001);
        check("n_to_pe_data",  64'(od(0)), 64'(mk(pl(2, 0), 3'd0, 3'd0)));
        tick();

        // ---------------- hop extremes: x=-4 -> W, x=+3 -> E ----------------
        drive(0, mk(pl(3, 0), 3'b100, 3'b001), 1'b1);
        drive(2, mk(pl(3, 1), 3'b011, 3'b001), 1'b1);
        tick();
        drive(0, '0, 1'b0);
        drive(2, '0, 1'b0);
        tick();
        check("extreme_valid", 64'(out_valid), 64'b11000);
        check("x_m4_to_w",     64'(od(4)), 64'(mk(pl(3, 0), 3'b101, 3'b001)));
        check("x_p3_to_e",     64'(od(3)), 64'(mk(pl(3, 1), 3'b010, 3'b001)));
        tick();

        // ---------------- 4 inputs x 4 flits contend for E ----------------
        // E pointer sits at 3 after the grant to S above, so service order is
        // W, PE, N, S repeated, one flit per cycle.
        order[0] = 4; order[1] = 0; order[2] = 1; order[3] = 2;
        foreach (sent[p]) sent[p] = 0;
        rcv = 0;
        first_cyc = -1;
        last_cyc  = -1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (out_valid[3]) begin
                if (rcv < 16) begin
                    check("rr_flit", 64'(od(3)),
                          64'(mk(pl(order[rcv % 4], rcv / 4), 3'd0, 3'd0)));
                end else begin
                    check("rr_extra_flit", 64'(rcv), 64'(15));
                end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                rcv++;
            end
            if (rcv == 16) break;
            for (int q = 0; q < 4; q++) begin
                int p;
                p = order[q];
                drive(p, mk(pl(p, sent[p]), 3'd1, 3'd0), sent[p] < 4);
            end
            for (int q = 0; q < 4; q++) begin
                if (in_valid[order[q]] && in_ready[order[q]]) sent[order[q]]++;
            end
            tick();
        end
        in_valid = '0;
        check("rr_count", 64'(rcv), 64'(16));
        check("rr_back_to_back", 64'(last_cyc - first_cyc), 64'(15));
        tick();
        tick();

        // ---------------- back-pressure on E for 10 cycles ----------------
        acc = 0;
        rcv = 0;
        hold_err = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            out_ready[3] = (cyc >= 10);
            if (cyc == 10) begin
                check("bp_accepts", 64'(acc), 64'(3));
                check("bp_in_ready_low", 64'(in_ready[0]), 64'(0));
                check("bp_held_valid", 64'(out_valid[3]), 64'(1));
                check("bp_held_data", 64'(od(3)), 64'(mk(pl(5, 0), 3'd0, 3'd0)));
            end
            if (cyc < 10 && out_valid[3] && od(3) !== mk(pl(5, 0), 3'd0, 3'd0)) hold_err++;
            if (out_valid[3] && out_ready[3]) begin
                if (rcv < 6) begin
                    check("bp_flit", 64'(od(3)), 64'(mk(pl(5, rcv), 3'd0, 3'd0)));
                end else begin
                    check("bp_extra_flit", 64'(rcv), 64'(5));
                end
                rcv++;
            end
            drive(0, mk(pl(5, acc), 3'd1, 3'd0), acc < 6);
            if (in_valid[0] && in_ready[0]) acc++;
            tick();
        end
        in_valid = '0;
        check("bp_hold_stable", 64'(hold_err), 64'(0));
        check("bp_total", 64'(rcv), 64'(6));

        // ---------------- reset pulse with 3 flits buffered ----------------
        out_ready[3] = 1'b0;
        acc = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            drive(0, mk(pl(6, acc), 3'd1, 3'd0), acc < 3);
            if (in_valid[0] && in_ready[0]) acc++;
            tick();
        end
        drive(0, '0, 1'b0);
        check("pre_rst_buffered", 64'(acc), 64'(3));
        check("pre_rst_valid", 64'(out_valid), 64'b01000);
        #3 rst_n = 1'b0;
        #1;
        check("pulse_out_valid", 64'(out_valid), 64'(0));
        check("pulse_in_ready",  64'(in_ready),  64'(0));
        check("pulse_out_data",  64'(|out_data), 64'(0));
        rst_n = 1'b1;
        out_ready = 5'b11111;
        seen = 0;
        tick();
        check("post_rst_in_ready", 64'(in_ready), 64'h1f);
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (out_valid != '0) seen++;
            tick();
        end
        check("post_rst_no_output", 64'(seen), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
